// File: rtl/lerp2_sweep_if.sv
// Signal bundle between lerp2_sweep and its neighbours.
//   cmd_*  : cell command channel (valid/ready) plus the error pulse
//   lerp_* : operands and start/done handshake to the lerp2 datapath
//   out_*  : interpolated-sample stream (valid/ready) tagged with (x,y,last)
// The master modport is the sweep sequencer. It masters the lerp2 start handshake and the
// output stream, and it answers the command channel.
// The slave modport is the surrounding environment: the command source, lerp2 and the consumer.
interface lerp2_sweep_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_p0, cmd_p1, cmd_p2, cmd_p3;
  logic [CW-1:0]    cmd_X, cmd_Y;
  logic             cmd_err;

  logic [WIDTH-1:0] lerp_p0, lerp_p1, lerp_p2, lerp_p3;
  logic [WIDTH-1:0] lerp_x, lerp_y, lerp_X, lerp_Y;
  logic             lerp_start;
  logic             lerp_done;
  logic [WIDTH-1:0] lerp_val;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [CW-1:0]    out_x, out_y;
  logic             out_last;

  modport master (
    input  cmd_valid, cmd_p0, cmd_p1, cmd_p2, cmd_p3, cmd_X, cmd_Y,
    output cmd_ready, cmd_err,
    output lerp_p0, lerp_p1, lerp_p2, lerp_p3, lerp_x, lerp_y, lerp_X, lerp_Y, lerp_start,
    input  lerp_done, lerp_val,
    output out_valid, out_val, out_x, out_y, out_last,
    input  out_ready
  );

  modport slave (
    output cmd_valid, cmd_p0, cmd_p1, cmd_p2, cmd_p3, cmd_X, cmd_Y,
    input  cmd_ready, cmd_err,
    input  lerp_p0, lerp_p1, lerp_p2, lerp_p3, lerp_x, lerp_y, lerp_X, lerp_Y, lerp_start,
    output lerp_done, lerp_val,
    input  out_valid, out_val, out_x, out_y, out_last,
    output out_ready
  );
endinterface

// File: rtl/lerp2_sweep.sv
// Cell sweep sequencer for lerp2. Takes one command (corners p0..p3, size X x Y), walks every
// sample x-fastest, runs one lerp2 op per sample and streams each result with its (x,y,last) tag.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : lerp2_sweep_if master side (command in, lerp2 handshake, output stream)
module lerp2_sweep #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FBITS = 16,
  parameter int unsigned CW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  lerp2_sweep_if.master bus
);

  // Counters are shifted into the fixed-point operand; the sign bit must stay clear.
  if (CW + FBITS > WIDTH - 1) begin : g_width_check
    $error("lerp2_sweep: CW + FBITS must not exceed WIDTH - 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [3:0][WIDTH-1:0]  p_q, p_d;
  logic [CW-1:0]          xn_q, xn_d, yn_q, yn_d;
  logic [CW-1:0]          x_q, x_d, y_q, y_d;
  logic                   err_q, err_d;
  logic                   ov_q, ov_d;
  logic [WIDTH-1:0]       val_q, val_d;
  logic [CW-1:0]          ox_q, ox_d, oy_q, oy_d;
  logic                   last_q, last_d;

  logic x_end, y_end;
  assign x_end = (x_q == xn_q - 1'b1);
  assign y_end = (y_q == yn_q - 1'b1);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    xn_d    = xn_q;
    yn_d    = yn_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = 1'b0;
    ov_d    = ov_q;
    val_d   = val_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_X == '0 || bus.cmd_Y == '0) begin
            err_d = 1'b1;
          end else begin
            p_d     = {bus.cmd_p3, bus.cmd_p2, bus.cmd_p1, bus.cmd_p0};
            xn_d    = bus.cmd_X;
            yn_d    = bus.cmd_Y;
            x_d     = '0;
            y_d     = '0;
            state_d = StIssue;
          end
        end
      end
      // Start pulse cycle; lerp_done seen here may be a stale level from the previous op.
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.lerp_done) begin
          ov_d    = 1'b1;
          val_d   = bus.lerp_val;
          ox_d    = x_q;
          oy_d    = y_q;
          last_d  = x_end && y_end;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          ov_d = 1'b0;
          if (last_q) begin
            state_d = StIdle;
          end else begin
            if (x_end) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
            state_d = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      p_q     <= '0;
      xn_q    <= '0;
      yn_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      val_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      xn_q    <= xn_d;
      yn_q    <= yn_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      val_q   <= val_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      last_q  <= last_d;
    end
  end

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.cmd_err    = err_q;
  assign bus.lerp_start = (state_q == StIssue);
  assign bus.lerp_p0    = p_q[0];
  assign bus.lerp_p1    = p_q[1];
  assign bus.lerp_p2    = p_q[2];
  assign bus.lerp_p3    = p_q[3];
  assign bus.lerp_x     = WIDTH'(x_q) << FBITS;
  assign bus.lerp_y     = WIDTH'(y_q) << FBITS;
  assign bus.lerp_X     = WIDTH'(xn_q) << FBITS;
  assign bus.lerp_Y     = WIDTH'(yn_q) << FBITS;
  assign bus.out_valid  = ov_q;
  assign bus.out_val    = val_q;
  assign bus.out_x      = ox_q;
  assign bus.out_y      = oy_q;
  assign bus.out_last   = last_q;

endmodule

// File: tb/tb_lerp2_sweep.sv
// Directed bench for lerp2_sweep with a behavioural lerp2 stand-in (bilinear, latency lat).
module tb_lerp2_sweep;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned FBITS = 16;
  localparam int unsigned CW    = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lerp2_sweep_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  lerp2_sweep #(.WIDTH(WIDTH), .FBITS(FBITS), .CW(CW)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // lerp2 model: independent of the DUT reset so a late done can arrive after a reset.
  int lat        = 1;
  bit level_mode = 1'b0;
  bit mdl_clr    = 1'b1;
  int cnt        = 0;
  bit busy       = 1'b0;

  function automatic logic [WIDTH-1:0] model_val();
    longint p0, p1, p2, p3, x, y, xn, yn, v;
    p0 = longint'($signed(bus.lerp_p0));
    p1 = longint'($signed(bus.lerp_p1));
    p2 = longint'($signed(bus.lerp_p2));
    p3 = longint'($signed(bus.lerp_p3));
    x  = longint'(bus.lerp_x >> FBITS);
    y  = longint'(bus.lerp_y >> FBITS);
    xn = longint'(bus.lerp_X >> FBITS);
    yn = longint'(bus.lerp_Y >> FBITS);
    if (xn * yn == 0) return '0;
    v = (p0 * (xn - x) * (yn - y) + p1 * x * (yn - y) + p2 * (xn - x) * y + p3 * x * y)
        / (xn * yn);
    return v[WIDTH-1:0];
  endfunction

  always @(posedge clk) begin
    if (mdl_clr) begin
      busy          <= 1'b0;
      cnt           <= 0;
      bus.lerp_done <= 1'b0;
      bus.lerp_val  <= '0;
    end else if (bus.lerp_start) begin
      busy          <= 1'b1;
      cnt           <= lat;
      bus.lerp_done <= 1'b0;
    end else if (busy) begin
      if (cnt <= 1) begin
        bus.lerp_done <= 1'b1;
        bus.lerp_val  <= model_val();
        busy          <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (!level_mode) begin
      bus.lerp_done <= 1'b0;
    end
  end

  int n_start = 0;
  int n_viol  = 0;
  int n_hs    = 0;
  always @(posedge clk) begin
    if (bus.lerp_start) n_start <= n_start + 1;
    if (bus.lerp_start && bus.out_valid) n_viol <= n_viol + 1;
    if (bus.out_valid && bus.out_ready) n_hs <= n_hs + 1;
  end

  task automatic set_cmd(input logic [WIDTH-1:0] p0, p1, p2, p3, input logic [CW-1:0] xn, yn);
    bus.cmd_p0 = p0;
    bus.cmd_p1 = p1;
    bus.cmd_p2 = p2;
    bus.cmd_p3 = p3;
    bus.cmd_X  = xn;
    bus.cmd_Y  = yn;
  endtask

  // Raise cmd_valid, return at the negedge after the accepting edge (cmd_valid still high).
  task automatic offer_cmd(output bit ok);
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.cmd_ready) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready got %b exp 1", bus.cmd_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); else passed++;
    checks++; if (bus.lerp_start !== 1'b0) $display("FAIL rst_lerp_start got %b exp 0", bus.lerp_start); else passed++;
    checks++; if (bus.cmd_err !== 1'b0) $display("FAIL rst_cmd_err got %b exp 0", bus.cmd_err); else passed++;
    checks++; if (bus.out_last !== 1'b0) $display("FAIL rst_out_last got %b exp 0", bus.out_last); else passed++;
    checks++; if (bus.out_val !== 32'h0) $display("FAIL rst_out_val got %h exp 0", bus.out_val); else passed++;
    checks++; if (bus.lerp_X !== 32'h0) $display("FAIL rst_lerp_X got %h exp 0", bus.lerp_X); else passed++;
    rst_n   = 1'b1;
    mdl_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] ev[4] = '{32'h0, 32'h10000, 32'h20000, 32'h30000};
    logic [CW-1:0]    ex[4] = '{8'd0, 8'd1, 8'd0, 8'd1};
    logic [CW-1:0]    ey[4] = '{8'd0, 8'd0, 8'd1, 8'd1};
    logic             el[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit ok;
    lat = 3;
    bus.out_ready = 1'b1;
    set_cmd(32'h0, 32'h20000, 32'h40000, 32'h60000, 8'd2, 8'd2);
    offer_cmd(ok);
    bus.cmd_valid = 1'b0;
    checks++; if (!ok) $display("FAIL t1_accept got timeout exp accept"); else passed++;
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      checks++; if (!ok) $display("FAIL t1_valid[%0d] got timeout exp out_valid", k); else passed++;
      checks++; if (bus.out_val !== ev[k]) $display("FAIL t1_val[%0d] got %h exp %h", k, bus.out_val, ev[k]); else passed++;
      checks++; if (bus.out_x !== ex[k] || bus.out_y !== ey[k])
        $display("FAIL t1_xy[%0d] got %0d,%0d exp %0d,%0d", k, bus.out_x, bus.out_y, ex[k], ey[k]); else passed++;
      checks++; if (bus.out_last !== el[k]) $display("FAIL t1_last[%0d] got %b exp %b", k, bus.out_last, el[k]); else passed++;
      @(negedge clk);
    end
    checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL t1_ready_after got %b exp 1", bus.cmd_ready); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL t1_valid_after got %b exp 0", bus.out_valid); else passed++;
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] ev[3] = '{32'h10000, 32'h20000, 32'h30000};
    logic             el[3] = '{1'b0, 1'b0, 1'b1};
    int s0, v0;
    bit ok;
    lat = 2;
    s0 = n_start;
    v0 = n_viol;
    bus.out_ready = 1'b0;
    set_cmd(32'h10000, 32'h40000, 32'h70000, 32'hFFFF0000, 8'd3, 8'd1);
    offer_cmd(ok);
    bus.cmd_valid = 1'b0;
    set_cmd(32'h55555, 32'h55555, 32'h55555, 32'h55555, 8'd7, 8'd7);
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      checks++; if (!ok) $display("FAIL t2_valid[%0d] got timeout exp out_valid", k); else passed++;
      checks++; if (bus.out_val !== ev[k]) $display("FAIL t2_val[%0d] got %h exp %h", k, bus.out_val, ev[k]); else passed++;
      repeat (5) @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_val !== ev[k] || bus.out_x !== 8'(k) || bus.out_y !== 8'd0)
        $display("FAIL t2_stall[%0d] got v=%b %h %0d,%0d exp v=1 %h %0d,0", k, bus.out_valid,
                 bus.out_val, bus.out_x, bus.out_y, ev[k], k); else passed++;
      checks++; if (bus.out_last !== el[k]) $display("FAIL t2_last[%0d] got %b exp %b", k, bus.out_last, el[k]); else passed++;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    repeat (4) @(negedge clk);
    checks++; if (n_start - s0 !== 3) $display("FAIL t2_starts got %0d exp 3", n_start - s0); else passed++;
    checks++; if (n_viol - v0 !== 0) $display("FAIL t2_start_while_valid got %0d exp 0", n_viol - v0); else passed++;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_err();
    int s0;
    bit ok, seen;
    s0 = n_start;
    seen = 1'b0;
    set_cmd(32'h10000, 32'h10000, 32'h10000, 32'h10000, 8'd0, 8'd4);
    offer_cmd(ok);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.cmd_err !== 1'b1) $display("FAIL t3_err_pulse got %b exp 1", bus.cmd_err); else passed++;
    @(negedge clk);
    checks++; if (bus.cmd_err !== 1'b0) $display("FAIL t3_err_clear got %b exp 0", bus.cmd_err); else passed++;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid || !bus.cmd_ready) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) $display("FAIL t3_no_activity got %b exp 0", seen); else passed++;
    checks++; if (n_start - s0 !== 0) $display("FAIL t3_starts got %0d exp 0", n_start - s0); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    seen = 1'b0;
    lat = 10;
    set_cmd(32'h10000, 32'h20000, 32'h30000, 32'h40000, 8'd4, 8'd4);
    offer_cmd(ok);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.lerp_start !== 1'b0)
      $display("FAIL t4_rst_ctrl got v=%b r=%b s=%b exp 0,1,0", bus.out_valid, bus.cmd_ready,
               bus.lerp_start); else passed++;
    checks++; if (bus.lerp_p0 !== 32'h0 || bus.lerp_X !== 32'h0)
      $display("FAIL t4_rst_ops got %h,%h exp 0,0", bus.lerp_p0, bus.lerp_X); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) $display("FAIL t4_late_done got out_valid %b exp 0", seen); else passed++;
    checks++; if (bus.cmd_ready !== 1'b1 || bus.out_val !== 32'h0)
      $display("FAIL t4_idle got r=%b val=%h exp 1,0", bus.cmd_ready, bus.out_val); else passed++;
    lat = 1;
    set_cmd(32'h12345, 32'h0, 32'h0, 32'h0, 8'd1, 8'd1);
    offer_cmd(ok);
    bus.cmd_valid = 1'b0;
    wait_valid(ok);
    checks++; if (!ok) $display("FAIL t4_valid got timeout exp out_valid"); else passed++;
    checks++; if (bus.out_val !== 32'h12345 || bus.out_last !== 1'b1 || bus.out_x !== 8'd0 || bus.out_y !== 8'd0)
      $display("FAIL t4_single got %h last=%b %0d,%0d exp 12345 last=1 0,0", bus.out_val,
               bus.out_last, bus.out_x, bus.out_y); else passed++;
    @(negedge clk);
  endtask

  task automatic test_level_done();
    logic [WIDTH-1:0] ev[2] = '{32'h10000, 32'h20000};
    int s0, h0;
    bit ok;
    level_mode = 1'b1;
    lat = 2;
    s0 = n_start;
    h0 = n_hs;
    set_cmd(32'h10000, 32'h30000, 32'h0, 32'h0, 8'd2, 8'd1);
    offer_cmd(ok);
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      checks++; if (bus.out_val !== ev[k] || bus.out_x !== 8'(k))
        $display("FAIL t5_val[%0d] got %h @%0d exp %h @%0d", k, bus.out_val, bus.out_x, ev[k], k); else passed++;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    checks++; if (n_start - s0 !== 2) $display("FAIL t5_starts got %0d exp 2", n_start - s0); else passed++;
    checks++; if (n_hs - h0 !== 2) $display("FAIL t5_results got %0d exp 2", n_hs - h0); else passed++;
    level_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    lat = 1;
    set_cmd(32'h10000, 32'h90000, 32'h50000, 32'h90000, 8'd1, 8'd2);
    offer_cmd(ok);
    set_cmd(32'h70000, 32'h0, 32'h0, 32'h0, 8'd1, 8'd1);
    checks++; if (bus.lerp_p0 !== 32'h10000 || bus.lerp_Y !== 32'h20000)
      $display("FAIL t6_ops_held got %h,%h exp 10000,20000", bus.lerp_p0, bus.lerp_Y); else passed++;
    wait_valid(ok);
    checks++; if (bus.out_val !== 32'h10000 || bus.out_y !== 8'd0 || bus.out_last !== 1'b0)
      $display("FAIL t6_a0 got %h y=%0d last=%b exp 10000 y=0 last=0", bus.out_val, bus.out_y,
               bus.out_last); else passed++;
    @(negedge clk);
    wait_valid(ok);
    checks++; if (bus.out_val !== 32'h30000 || bus.out_y !== 8'd1 || bus.out_last !== 1'b1)
      $display("FAIL t6_a1 got %h y=%0d last=%b exp 30000 y=1 last=1", bus.out_val, bus.out_y,
               bus.out_last); else passed++;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL t6_ready_gap got %b exp 1", bus.cmd_ready); else passed++;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b0) $display("FAIL t6_second_accept got %b exp 0", bus.cmd_ready); else passed++;
    bus.cmd_valid = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || bus.out_val !== 32'h70000 || bus.out_last !== 1'b1)
      $display("FAIL t6_b0 got ok=%b %h last=%b exp 1 70000 last=1", ok, bus.out_val,
               bus.out_last); else passed++;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL t6_idle got %b exp 1", bus.cmd_ready); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_cmd('0, '0, '0, '0, '0, '0);
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_reset_mid();
    test_level_done();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
